mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit with HI/LO result registers for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU issued from the execute stage. The Hi and Lo outputs feed the 32-bit 2-to-1 result mux (Sel chooses Hi for MFHI or Lo for MFLO) that drives writeback. It also accepts direct MTHI/MTLO writes.

## Interface
- ITER, default 32: number of iteration cycles per operation, fixed at the operand width.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  operation request; sampled only in IDLE.
- Op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  in  32  multiplicand or dividend (rs); sampled with Start.
- B  in  32  multiplier or divisor (rt); sampled with Start.
- HiWe  in  1  MTHI: write WrData to Hi.
- LoWe  in  1  MTLO: write WrData to Lo.
- WrData  in  32  MTHI/MTLO data.
- Busy  out  1  operation in progress; the pipeline stalls MFHI/MFLO while this is high.
- Done  out  1  one-cycle pulse when Hi/Lo hold a new result.
- Hi  out  32  HI register: upper product word or remainder.
- Lo  out  32  LO register: lower product word or quotient.

## Operation
- **Reset values:** state IDLE, Hi=0, Lo=0, Busy=0, Done=0, iteration counter 0.
- **States:** IDLE, CALC, FINISH.
  - IDLE→CALC: Start=1.
  - CALC→FINISH: counter reaches ITER-1.
  - FINISH→IDLE: unconditional.
- **Capture (IDLE with Start):**
  - Latch Op.
  - For signed ops, latch |A| and |B| as 32-bit unsigned magnitudes (|0x80000000| = 0x80000000).
  - Latch neg_q = A[31]^B[31] and neg_r = A[31]. Both are 0 for the unsigned ops.
- **Multiply (CALC):** shift-add, one multiplier bit per cycle, LSB first. The 64-bit accumulator is exact after ITER cycles.
- **Divide (CALC):** restoring division, one quotient bit per cycle, MSB first. The remainder is a 33-bit trial subtraction.
- **FINISH writeback:**
  - Multiply: if neg_q, the 64-bit product is two's-complement negated. Then Hi = product[63:32] and Lo = product[31:0].
  - Divide: Lo = quotient, negated if neg_q. Hi = remainder, negated if neg_r. The remainder takes the sign of the dividend.
- **Divide by zero (B=0, DIV or DIVU):** Lo = 0xFFFFFFFF, Hi = A as sampled. No sign fixup is applied. Full latency still applies.
- **Signed overflow (DIV 0x80000000 / 0xFFFFFFFF):** Lo = 0x80000000, Hi = 0. This falls out of the magnitude path and needs no special case.
- **MTHI/MTLO:**
  - HiWe/LoWe take effect on the next edge only when Busy=0. They are ignored while Busy=1.
  - HiWe/LoWe together with Start in IDLE: the write applies, and the operation starts and later overwrites the written registers.
- **Start while Busy:** ignored; it is not queued.
- **Operand stability:** changes to Op, A or B after capture have no effect.

## Timing
- Start is sampled at edge 0.
- Busy=1 in cycles 1 through ITER+1 (CALC for ITER cycles, then FINISH).
- Hi/Lo update at the edge ending FINISH. Done=1 and Busy=0 in cycle ITER+2 (cycle 34 at default), for exactly one cycle.
- Back-to-back: Start asserted in the Done cycle is accepted, since the state is IDLE.
- Hi/Lo are register outputs with no combinational path from the inputs.
- Reset mid-operation: the operation aborts with no Done pulse; Hi/Lo go to 0 and state returns to IDLE on that edge.

## Structure
- Shared package mdu_pkg holds:
  - the Op encodings OP_MULT, OP_MULTU, OP_DIV and OP_DIVU;
  - the state encoding for IDLE, CALC and FINISH;
  - ITER=32.
- The decoder uses the same Op constants.
- Single module; no sub-module. The 32/64-bit conditional negation is a local function.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → Done in cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001; Busy high in cycles 1–33.
- MULT A=0xFFFFFFFD (-3), B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=100, B=0 → Lo=0xFFFFFFFF, Hi=100.
- DIV A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Control boundaries:
  - Start at cycle 10 of an operation → ignored.
  - HiWe=1, WrData=0x1234 while Busy → Hi unchanged.
  - HiWe=1 in IDLE → Hi=0x1234 next cycle.
  - Start in the Done cycle → second result appears 34 cycles later.
  - Reset at cycle 15 → Hi=Lo=0, Busy=0, no Done.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the MIPS multiply/divide unit: op encodings, FSM states, iteration count.
package mdu_pkg;
  localparam int ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// One product/quotient bit per cycle on magnitudes; signs are fixed up in FINISH.
module mult_div_unit #(
  parameter int ITER = mdu_pkg::ITER
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWe,
  input  logic        LoWe,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER);

  function automatic logic [31:0] cneg32(input logic [31:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] x, input logic en);
    return en ? -x : x;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [63:0]   acc_q, acc_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic          sgn, is_div, start_div;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   trial, sum;
  logic [63:0]   prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sgn       = (Op == OP_MULT) || (Op == OP_DIV);
    start_div = (Op == OP_DIV) || (Op == OP_DIVU);
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    a_mag     = cneg32(A, sgn & A[31]);
    b_mag     = cneg32(B, sgn & B[31]);
    trial     = {acc_q[63:32], acc_q[31]} - {1'b0, opnd_q};
    sum       = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    prod      = cneg64(acc_q, qneg_q);

    case (state_q)
      ST_IDLE: begin
        if (HiWe) hi_d = WrData;
        if (LoWe) lo_d = WrData;
        if (Start) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          op_d    = Op;
          qneg_d  = sgn & (A[31] ^ B[31]);
          rneg_d  = sgn & A[31];
          // acc low word is the bit source: multiplier for MULT, dividend for DIV
          opnd_d  = start_div ? b_mag : a_mag;
          acc_d   = {32'd0, start_div ? a_mag : b_mag};
        end
      end
      ST_CALC: begin
        if (is_div) begin
          if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
          else            acc_d = {acc_q[62:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div) begin
          // With a zero divisor every trial succeeds, so the remainder is |A| and
          // the sign fixup restores A; only the quotient needs forcing.
          lo_d = (opnd_q == 32'd0) ? 32'hFFFF_FFFF : cneg32(acc_q[31:0], qneg_q);
          hi_d = cneg32(acc_q[63:32], rneg_q);
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      opnd_q  <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {Hi,Lo} queued at issue, compared at Done.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, HiWe, LoWe;
  logic [1:0]  Op;
  logic [31:0] A, B, WrData;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] sb_q[$];

  always #5 Clk = ~Clk;

  mult_div_unit #(.ITER(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; Start is sampled at the following posedge (edge 0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; Op = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  // Returns the cycle index (1 = first cycle after edge 0) of Done, 0 on timeout.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Done) cyc = i;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 0; HiWe = 0; LoWe = 0; Op = 0; A = 0; B = 0; WrData = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    n_total++; if (Hi !== 32'd0) $display("FAIL reset_hi: got %h expected 0", Hi); else n_pass++;
    n_total++; if (Lo !== 32'd0) $display("FAIL reset_lo: got %h expected 0", Lo); else n_pass++;
    n_total++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else n_pass++;
    n_total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Done); else n_pass++;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge Clk);
    HiWe = 1; WrData = 32'h1234;
    @(posedge Clk); #1 HiWe = 0;
    @(negedge Clk);
    n_total++; if (Hi !== 32'h1234) $display("FAIL mthi_idle: got %h expected 00001234", Hi); else n_pass++;
    LoWe = 1; WrData = 32'h5678;
    @(posedge Clk); #1 LoWe = 0;
    @(negedge Clk);
    n_total++; if (Lo !== 32'h5678) $display("FAIL mtlo_idle: got %h expected 00005678", Lo); else n_pass++;
    n_total++; if (Hi !== 32'h1234) $display("FAIL mtlo_keeps_hi: got %h expected 00001234", Hi); else n_pass++;
  endtask

  task automatic test_multu_timing();
    int cyc, bc;
    logic [63:0] exp;
    sb_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    exp = sb_q.pop_front();
    n_total++; if (cyc != 34) $display("FAIL multu_done_cycle: got %0d expected 34", cyc); else n_pass++;
    n_total++; if (bc != 33) $display("FAIL multu_busy_cycles: got %0d expected 33", bc); else n_pass++;
    n_total++; if ({Hi, Lo} !== exp) $display("FAIL multu_result: got %h expected %h", {Hi, Lo}, exp); else n_pass++;
    @(negedge Clk);
    n_total++; if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL multu_done_pulse: got done=%b busy=%b expected 0 0", Done, Busy); else n_pass++;
  endtask

  task automatic test_arith();
    logic [1:0]  ops [5] = '{OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd1000};
    logic [31:0] bs  [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
    logic [63:0] ex  [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFEB}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                             {32'd100, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}, {32'd6, 32'd142}};
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int cyc, bc;
    for (int i = 0; i < 14; i++) begin
      if (i < 5) begin
        op = ops[i]; a = as[i]; b = bs[i];
        sb_q.push_back(ex[i]);
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        if (i == 13) b = 32'd0;
        sb_q.push_back(model(op, a, b));
      end
      @(negedge Clk);
      issue(op, a, b);
      wait_done(cyc, bc);
      exp = sb_q.pop_front();
      n_total++; if ({Hi, Lo} !== exp) $display("FAIL arith_%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {Hi, Lo}, exp); else n_pass++;
      n_total++; if (cyc != 34) $display("FAIL arith_%0d_latency: got %0d expected 34", i, cyc); else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc = 0, ndone = 0;
    logic [31:0] hi_mid = 32'hX;
    logic [63:0] exp;
    @(negedge Clk);
    HiWe = 1; WrData = 32'hAAAA;
    @(posedge Clk); #1 HiWe = 0;
    @(negedge Clk);
    sb_q.push_back({32'd0, 32'd15});
    issue(OP_MULTU, 32'd3, 32'd5);
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clk);
      if (Done) begin ndone++; if (cyc == 0) cyc = i; end
      if (i == 20) hi_mid = Hi;
      if (i == 34 && Done) begin
        exp = sb_q.pop_front();
        n_total++; if ({Hi, Lo} !== exp) $display("FAIL busy_ignore_result: got %h expected %h", {Hi, Lo}, exp); else n_pass++;
      end
      Start = 0; HiWe = 0;
      if (i == 9)  begin Start = 1; Op = OP_DIVU; A = 32'd1; B = 32'd1; end
      if (i == 12) begin HiWe = 1; WrData = 32'h1234; end
    end
    n_total++; if (hi_mid !== 32'hAAAA) $display("FAIL mthi_while_busy: got %h expected 0000aaaa", hi_mid); else n_pass++;
    n_total++; if (cyc != 34) $display("FAIL busy_ignore_latency: got %0d expected 34", cyc); else n_pass++;
    n_total++; if (ndone != 1) $display("FAIL start_while_busy: got %0d done pulses expected 1", ndone); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL busy_ignore_scoreboard: got %0d pending expected 0", sb_q.size()); else n_pass++;
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [63:0] exp;
    sb_q.push_back(model(OP_MULT, 32'hFFFF_FF00, 32'h0001_0001));
    sb_q.push_back(model(OP_DIVU, 32'hDEAD_BEEF, 32'd1234));
    @(negedge Clk);
    issue(OP_MULT, 32'hFFFF_FF00, 32'h0001_0001);
    wait_done(cyc, bc);
    exp = sb_q.pop_front();
    n_total++; if ({Hi, Lo} !== exp) $display("FAIL b2b_first: got %h expected %h", {Hi, Lo}, exp); else n_pass++;
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd1234);
    wait_done(cyc, bc);
    exp = sb_q.pop_front();
    n_total++; if (cyc != 34) $display("FAIL b2b_latency: got %0d expected 34", cyc); else n_pass++;
    n_total++; if ({Hi, Lo} !== exp) $display("FAIL b2b_second: got %h expected %h", {Hi, Lo}, exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge Clk);
    HiWe = 1; LoWe = 1; WrData = 32'h5555;
    @(posedge Clk); #1 HiWe = 0; LoWe = 0;
    @(negedge Clk);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    n_total++; if ({Hi, Lo} !== 64'd0) $display("FAIL reset_mid_hilo: got %h expected 0", {Hi, Lo}); else n_pass++;
    n_total++; if (Busy !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", Busy); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    n_total++; if (ndone != 0) $display("FAIL reset_mid_no_done: got %0d pulses expected 0", ndone); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_multu_timing();
    test_arith();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
